// File: rtl/sdram_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

  // A requester is active while it holds either its read or its write level.
  function automatic logic req_of(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Request/response bundle shared by the requester ports and the controller port.
interface sdram_arbiter_if
  import sdram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              ready;

  modport master (output addr, wdata, read, write, input rdata, busy, ready);
  modport slave  (input addr, wdata, read, write, output rdata, busy, ready);

endinterface

// File: rtl/rr_pick2.sv
// Two-request round-robin selector; on a tie the port not granted last time wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_idx
);

  // Pick the single requester, or alternate against the previous grant.
  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_idx = ~last;
    end else if (req1) begin
      gnt_idx = 1'b1;
    end else begin
      gnt_idx = 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between two requesters.
// Optional WAIT watchdog with sticky err flag: define ARB_TIMEOUT_EN.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  sdram_arbiter_if.slave   m0,
  sdram_arbiter_if.slave   m1,
  sdram_arbiter_if.master  sd,
  output logic             err
);

  arb_state_e        state_r;
  logic              last_grant_r;
  logic              grant_r;
  logic              op_write_r;
  logic [ADDR_W-1:0] sd_addr_r;
  logic [DATA_W-1:0] sd_wdata_r;
  logic              sd_read_r;
  logic              sd_write_r;
  logic [DATA_W-1:0] m0_rdata_r;
  logic [DATA_W-1:0] m1_rdata_r;
  logic              m0_ready_r;
  logic              m1_ready_r;

  logic              req0_s;
  logic              req1_s;
  logic              gnt_valid_s;
  logic              gnt_idx_s;
  logic              cap_done_s;
  logic [DATA_W-1:0] cap_data_s;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] TIMEOUT_FILL = {(DATA_W / 16){TIMEOUT_RDATA}};
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             err_r;
`endif

  assign req0_s = req_of(m0.read, m0.write);
  assign req1_s = req_of(m1.read, m1.write);

  rr_pick2 u_pick (
    .req0      (req0_s),
    .req1      (req1_s),
    .last      (last_grant_r),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // WAIT completes on the controller's ready, or on watchdog expiry when enabled.
  always_comb begin
    cap_done_s = sd.ready;
    cap_data_s = sd.rdata;
`ifdef ARB_TIMEOUT_EN
    if (!sd.ready && (tmo_cnt_r == TMO_LAST)) begin
      cap_done_s = 1'b1;
      cap_data_s = TIMEOUT_FILL;
    end else begin
      cap_done_s = sd.ready;
    end
`endif
  end

  // Transaction FSM with latched command and registered strobes/ready pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      op_write_r   <= 1'b0;
      sd_addr_r    <= {ADDR_W{1'b0}};
      sd_wdata_r   <= {DATA_W{1'b0}};
      sd_read_r    <= 1'b0;
      sd_write_r   <= 1'b0;
      m0_rdata_r   <= {DATA_W{1'b0}};
      m1_rdata_r   <= {DATA_W{1'b0}};
      m0_ready_r   <= 1'b0;
      m1_ready_r   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_r    <= {TMO_W{1'b0}};
      err_r        <= 1'b0;
`endif
    end else begin
      sd_read_r  <= 1'b0;
      sd_write_r <= 1'b0;
      m0_ready_r <= 1'b0;
      m1_ready_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            grant_r      <= gnt_idx_s;
            last_grant_r <= gnt_idx_s;
            sd_addr_r    <= gnt_idx_s ? m1.addr  : m0.addr;
            sd_wdata_r   <= gnt_idx_s ? m1.wdata : m0.wdata;
            op_write_r   <= gnt_idx_s ? m1.write : m0.write;
            state_r      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!sd.busy) begin
            sd_write_r <= op_write_r;
            sd_read_r  <= ~op_write_r;
            state_r    <= ST_WAIT;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_r  <= {TMO_W{1'b0}};
`endif
          end
        end
        ST_WAIT: begin
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_r <= tmo_cnt_r + 1'b1;
`endif
          if (cap_done_s) begin
            if (grant_r) begin
              m1_rdata_r <= cap_data_s;
              m1_ready_r <= 1'b1;
            end else begin
              m0_rdata_r <= cap_data_s;
              m0_ready_r <= 1'b1;
            end
            state_r <= ST_DONE;
`ifdef ARB_TIMEOUT_EN
            if (!sd.ready) begin
              err_r <= 1'b1;
            end
`endif
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // A port stops seeing busy in the cycle its ready pulse is presented.
  assign m0.busy  = req0_s & ~((state_r == ST_DONE) & (grant_r == 1'b0));
  assign m1.busy  = req1_s & ~((state_r == ST_DONE) & (grant_r == 1'b1));
  assign m0.rdata = m0_rdata_r;
  assign m1.rdata = m1_rdata_r;
  assign m0.ready = m0_ready_r;
  assign m1.ready = m1_ready_r;

  assign sd.addr  = sd_addr_r;
  assign sd.wdata = sd_wdata_r;
  assign sd.read  = sd_read_r;
  assign sd.write = sd_write_r;

`ifdef ARB_TIMEOUT_EN
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: cycle tables plus hand-written multi-cycle sequences.
module tb_sdram_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic err;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   seen_v;
  int   exp_p;

  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) m0_if ();
  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) m1_if ();
  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) sd_if ();

  sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .sd  (sd_if),
    .err (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m0_rd, m0_wr, m1_rd, m1_wr, sd_bsy, sd_rdy;
    logic [15:0] sd_rd;
    logic        e_srd, e_swr, e_r0, e_r1, e_b0, e_b1;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic [5:0] ib, input logic [15:0] rd, input logic [5:0] eb);
    vec_t v;
    {v.m0_rd, v.m0_wr, v.m1_rd, v.m1_wr, v.sd_bsy, v.sd_rdy} = ib;
    v.sd_rd = rd;
    {v.e_srd, v.e_swr, v.e_r0, v.e_r1, v.e_b0, v.e_b1} = eb;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(output int seen);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (sd_if.read === 1'b1 || sd_if.write === 1'b1) begin
        seen = 1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish, expected finish before 50000");
    $fatal(1, "bench stalled");
  end

  initial begin
    // Port-0 read (rows 0-7), then port-0 read+write resolved as write (rows 8-13).
    vecs[0]  = mk(6'b100000, 16'h0000, 6'b000010);
    vecs[1]  = mk(6'b100000, 16'h0000, 6'b000010);
    vecs[2]  = mk(6'b100000, 16'h0000, 6'b100010);
    vecs[3]  = mk(6'b100000, 16'h0000, 6'b000010);
    vecs[4]  = mk(6'b100000, 16'h0000, 6'b000010);
    vecs[5]  = mk(6'b100001, 16'hBEEF, 6'b000010);
    vecs[6]  = mk(6'b000000, 16'h0000, 6'b001000);
    vecs[7]  = mk(6'b000000, 16'h0000, 6'b000000);
    vecs[8]  = mk(6'b110000, 16'h0000, 6'b000010);
    vecs[9]  = mk(6'b110000, 16'h0000, 6'b000010);
    vecs[10] = mk(6'b110000, 16'h0000, 6'b010010);
    vecs[11] = mk(6'b110001, 16'h1234, 6'b000010);
    vecs[12] = mk(6'b110000, 16'h0000, 6'b001000);
    vecs[13] = mk(6'b000000, 16'h0000, 6'b000000);

    rst = 1'b1;
    m0_if.addr = 24'h000123; m0_if.wdata = 16'h3C3C; m0_if.read = 1'b0; m0_if.write = 1'b0;
    m1_if.addr = 24'h000000; m1_if.wdata = 16'h0000; m1_if.read = 1'b0; m1_if.write = 1'b0;
    sd_if.busy = 1'b0; sd_if.ready = 1'b0; sd_if.rdata = 16'h0000;
    tick();
    tick();
    chk("rst_strobes", 32'({sd_if.read, sd_if.write}), 32'h0);
    chk("rst_readys", 32'({m0_if.ready, m1_if.ready}), 32'h0);
    chk("rst_sd_addr", 32'(sd_if.addr), 32'h0);
    chk("rst_sd_wdata", 32'(sd_if.wdata), 32'h0);
    chk("rst_rdata", 32'({m0_if.rdata, m1_if.rdata}), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      m0_if.read = vecs[i].m0_rd; m0_if.write = vecs[i].m0_wr;
      m1_if.read = vecs[i].m1_rd; m1_if.write = vecs[i].m1_wr;
      sd_if.busy = vecs[i].sd_bsy; sd_if.ready = vecs[i].sd_rdy; sd_if.rdata = vecs[i].sd_rd;
      #1;
      chk($sformatf("tbl%0d_sd_read", i), 32'(sd_if.read), 32'(vecs[i].e_srd));
      chk($sformatf("tbl%0d_sd_write", i), 32'(sd_if.write), 32'(vecs[i].e_swr));
      chk($sformatf("tbl%0d_m0_ready", i), 32'(m0_if.ready), 32'(vecs[i].e_r0));
      chk($sformatf("tbl%0d_m1_ready", i), 32'(m1_if.ready), 32'(vecs[i].e_r1));
      chk($sformatf("tbl%0d_m0_busy", i), 32'(m0_if.busy), 32'(vecs[i].e_b0));
      chk($sformatf("tbl%0d_m1_busy", i), 32'(m1_if.busy), 32'(vecs[i].e_b1));
      if (i == 2) chk("tbl_rd_sd_addr", 32'(sd_if.addr), 32'h000123);
      if (i == 6) chk("tbl_rd_m0_rdata", 32'(m0_if.rdata), 32'hBEEF);
      if (i == 6) chk("tbl_rd_m1_rdata", 32'(m1_if.rdata), 32'h0000);
      if (i == 10) chk("tbl_wr_sd_wdata", 32'(sd_if.wdata), 32'h3C3C);
      tick();
    end

    // Port-1 write stalled by controller busy; inputs change/drop after grant.
    m1_if.addr = 24'h00ABCD; m1_if.wdata = 16'h5A5A; m1_if.write = 1'b1;
    sd_if.busy = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) begin m1_if.wdata = 16'h1111; m1_if.addr = 24'h000777; end
      if (k == 3) m1_if.write = 1'b0;
      if (k == 6) sd_if.busy = 1'b0;
      #1;
      chk($sformatf("busy%0d_no_strobe", k), 32'({sd_if.read, sd_if.write}), 32'h0);
      tick();
    end
    chk("busy_wr_strobe", 32'({sd_if.read, sd_if.write}), 32'h1);
    chk("busy_sd_addr", 32'(sd_if.addr), 32'h00ABCD);
    chk("busy_sd_wdata", 32'(sd_if.wdata), 32'h5A5A);
    tick();
    chk("busy_strobe_once", 32'(sd_if.write), 32'h0);
    sd_if.ready = 1'b1; sd_if.rdata = 16'h0042;
    tick();
    sd_if.ready = 1'b0;
    chk("busy_m1_ready", 32'({m1_if.ready, m0_if.ready}), 32'h2);
    tick();
    chk("busy_ready_pulse", 32'(m1_if.ready), 32'h0);
    chk("busy_m1_rdata", 32'(m1_if.rdata), 32'h0042);

    // Asynchronous reset while a port-0 read is in WAIT.
    m0_if.addr = 24'h004C10; m0_if.read = 1'b1;
    tick();
    tick();
    chk("arst_pre_strobe", 32'(sd_if.read), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_strobe_drop", 32'({sd_if.read, sd_if.write}), 32'h0);
    chk("arst_ready_drop", 32'({m0_if.ready, m1_if.ready}), 32'h0);
    chk("arst_sd_addr", 32'(sd_if.addr), 32'h0);
    tick();
    m0_if.addr = 24'h004C00; m1_if.addr = 24'h100000; m1_if.read = 1'b1;
    rst = 1'b0;

    // Continuous tie from reset: grants alternate starting with port 0.
    for (int t = 0; t < 6; t++) begin
      exp_p = t % 2;
      wait_strobe(seen_v);
      chk($sformatf("fair%0d_strobe", t), 32'(seen_v), 32'h1);
      chk($sformatf("fair%0d_addr", t), 32'(sd_if.addr), (exp_p == 1) ? 32'h100000 : 32'h004C00);
      chk($sformatf("fair%0d_other_busy", t), 32'((exp_p == 1) ? m0_if.busy : m1_if.busy), 32'h1);
      tick();
      tick();
      sd_if.ready = 1'b1; sd_if.rdata = 16'hA000 + 16'(t);
      tick();
      sd_if.ready = 1'b0;
      if (t == 5) begin m0_if.read = 1'b0; m1_if.read = 1'b0; end
      #1;
      chk($sformatf("fair%0d_ready", t), 32'({m1_if.ready, m0_if.ready}), (exp_p == 1) ? 32'h2 : 32'h1);
      chk($sformatf("fair%0d_rdata", t), 32'((exp_p == 1) ? m1_if.rdata : m0_if.rdata), 32'hA000 + 32'(t));
      tick();
    end
    tick();

`ifdef ARB_TIMEOUT_EN
    // No controller response: watchdog completes the read after 16 WAIT cycles.
    m0_if.addr = 24'h000010; m0_if.read = 1'b1;
    wait_strobe(seen_v);
    chk("tmo_strobe", 32'(seen_v), 32'h1);
    repeat (15) tick();
    chk("tmo_not_yet", 32'(m0_if.ready), 32'h0);
    tick();
    m0_if.read = 1'b0;
    chk("tmo_ready", 32'(m0_if.ready), 32'h1);
    chk("tmo_rdata", 32'(m0_if.rdata), 32'hDEAD);
    chk("tmo_err", 32'(err), 32'h1);
    tick();
    m1_if.read = 1'b1;
    wait_strobe(seen_v);
    tick();
    sd_if.ready = 1'b1; sd_if.rdata = 16'h7777;
    tick();
    sd_if.ready = 1'b0; m1_if.read = 1'b0;
    chk("tmo_next_ready", 32'(m1_if.ready), 32'h1);
    chk("tmo_err_sticky", 32'(err), 32'h1);
    tick();
`else
    chk("err_tied_low", 32'(err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters.
- Port 0 is the CPU data path, covering the window at 0x4C00 and above after the top-level decode.
- Port 1 is a bulk requester, such as a VGA refill or DMA engine.
- Sits between the top-level address decode and the sdram controller, in the controller's clock domain.
- Uses round-robin arbitration. Address and write data are latched per transaction, and read data is returned with a one-cycle ready pulse.

Parameters:
- ADDR_W, 24, SDRAM word address width.
- DATA_W, 16, data word width.
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit in clk cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  controller clock, same as the sdram controller clock.
- rst  in  1  reset, asynchronous, active-high.
- m0_addr  in  ADDR_W  port 0 word address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_read  in  1  port 0 read request, level, held until m0_ready.
- m0_write  in  1  port 0 write request, level, held until m0_ready.
- m0_rdata  out  DATA_W  port 0 read data, valid while m0_ready is high.
- m0_busy  out  1  port 0 request pending and not yet completed.
- m0_ready  out  1  port 0 completion pulse, one cycle.
- m1_addr, m1_wdata, m1_read, m1_write, m1_rdata, m1_busy, m1_ready: same as port 0, for port 1.
- sd_addr  out  ADDR_W  to controller, latched address.
- sd_wdata  out  DATA_W  to controller, latched write data.
- sd_read  out  1  controller read strobe, one cycle.
- sd_write  out  1  controller write strobe, one cycle.
- sd_busy  in  1  controller busy.
- sd_ready  in  1  controller completion pulse; sd_rdata is valid in the same cycle.
- sd_rdata  in  DATA_W  controller read data.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), grant=0.
  - sd_read=sd_write=0, sd_addr=sd_wdata=0.
  - m*_ready=0, m*_rdata=0, err=0.
- State machine IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - req_n = mN_read | mN_write.
  - If only one port requests, grant that port.
  - If both request, grant ~last_grant.
  - On grant: latch addr, wdata and op (write wins if both read and write are asserted), set last_grant=grant, go to ISSUE.
- ISSUE:
  - If sd_busy=0, assert sd_write or sd_read for exactly one cycle, then go to WAIT.
  - Otherwise stay in ISSUE with strobes low.
- WAIT:
  - Strobes stay low.
  - On sd_ready: capture sd_rdata into the granted port's mN_rdata register, go to DONE.
- DONE:
  - mN_ready=1 for the granted port only, for one cycle (registered).
  - mN_rdata holds its value until that port's next completion.
  - Go to IDLE.
  - Requests are not sampled in DONE, so a requester drops its request in the same cycle it sees ready.
- Busy outputs:
  - mN_busy = req_n & ~(state==DONE & grant==N). Combinational.
  - A requester waiting for the grant sees busy=1.
- Latency:
  - Uncontended, controller idle: request at cycle 0, sd strobe at cycle 2, mN_ready one cycle after sd_ready.
  - Minimum back-to-back turnaround: 4 cycles plus controller latency.
- sd_addr and sd_wdata stay stable from ISSUE through DONE and change only in IDLE on a grant.
- Requests dropped before grant are ignored. Requests dropped after grant still complete, and the ready pulse is generated anyway.
- Fairness: with both ports requesting continuously, grants strictly alternate 0,1,0,1.
- Reset mid-transaction aborts immediately and no ready is issued. The controller is reset by the same rst.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT.
  - When it reaches TIMEOUT_CYCLES without sd_ready, the arbiter goes to DONE with mN_rdata = {DATA_W/16{16'hDEAD}}.
  - err is set to 1 and stays sticky until rst.
  - The counter clears on entering WAIT.
- When undefined:
  - WAIT waits indefinitely.
  - err is tied to 0 and no counter exists.

Decomposition:
- Shared package (sdram_pkg): state encoding localparams (ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_DONE=3), the TIMEOUT_RDATA constant 16'hDEAD, and the default ADDR_W and DATA_W.
- One natural sub-module, rr_pick2: two-request round-robin selector (inputs req0, req1, last; outputs gnt_valid, gnt_idx). Purely combinational.

Test Plan:
- Single port-0 read, addr 0x000123, controller returns 0xBEEF 3 cycles after the strobe -> sd_read pulses once at cycle 2, m0_ready at cycle 6 with m0_rdata=0xBEEF, m1_ready stays 0.
- Both ports assert reads at the same cycle, then hold and re-request continuously for 6 transactions -> first grant goes to port 0, and sd_addr shows the m0/m1 addresses strictly alternating.
- Port 1 write, addr 0x00ABCD, data 0x5A5A, with sd_busy held high for 5 cycles after the grant -> sd_write asserts only in the first cycle sd_busy=0, with sd_addr/sd_wdata equal to 0x00ABCD/0x5A5A.
- Port 0 holds both read and write -> a write is issued. m0_busy stays 1 until the m0_ready cycle and is 0 in that cycle.
- rst asserted asynchronously mid-WAIT -> all strobes and ready outputs drop immediately. After release, state is IDLE and the next tie grants port 0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no sd_ready -> m0_ready after 16 WAIT cycles with rdata 0xDEAD and err=1, and err stays 1 across later transactions.
